fft_bitrev_buf: RTL and testbench

- Sits directly downstream of the overlap-save block buffer and upstream of the radix-2 DIT FFT core.
- Captures each 2N-sample frame (start pulse, then a valid burst) into a ping-pong pair of banks, writing at bit-reversed addresses.
- Replays each frame to the FFT core in bit-reversed order through a valid/ready handshake.
- Absorbs the unthrottled upstream burst and decouples it from FFT-core stalls.

---
 rtl/fft_bitrev_buf.sv | 241 ++++++++++++++++++++++++
 tb/tb_fft_bitrev_buf.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_buf.sv
// ============================================================================
// Module   : fft_bitrev_buf
// Purpose  : Ping-pong frame buffer feeding a radix-2 DIT FFT core; captures
//            2N-sample frames and replays them through a valid/ready port.
//            Macro FFT_BITREV_EN selects bit-reversed write addressing
//            (undefined: natural-order ping-pong reframing buffer).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_bitrev_buf #(
    parameter int NFFT = 32,
    parameter int WN   = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic signed [WN-1:0] i_xI,
    input  logic signed [WN-1:0] i_xQ,
    input  logic                 i_ready,
    output logic                 o_start,
    output logic                 o_valid,
    output logic                 o_last,
    output logic signed [WN-1:0] o_xI,
    output logic signed [WN-1:0] o_xQ,
    output logic                 o_overrun,
    output logic                 o_sync_err
);

    localparam int AW = $clog2(NFFT);
    localparam logic [AW-1:0] c_last_addr = AW'(NFFT - 1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PRE  = 2'd1,
        R_SEND = 2'd2
    } rstate_t;

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic [AW-1:0]     r_wcnt, w_wcnt_nxt;
    logic [AW-1:0]     r_raddr, w_raddr_nxt;
    logic              r_wbank, w_wbank_nxt;
    logic              r_rbank, w_rbank_nxt;
    logic [1:0]        r_full, w_full_set, w_full_clr;
    logic              r_overrun, w_overrun_nxt;
    logic              r_sync_err, w_sync_err_nxt;
    logic              r_start, w_start_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_last, w_last_nxt;
    logic [WN-1:0]     r_xI, w_xI_nxt;
    logic [WN-1:0]     r_xQ, w_xQ_nxt;
    logic              w_we;
    logic              w_do_start;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_rd_addr;
    logic [2*WN-1:0]   w_rd_data;

    logic [2*WN-1:0]   r_mem [0:2*NFFT-1];

`ifdef FFT_BITREV_EN
    for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
        assign w_waddr[gi] = r_wcnt[AW-1-gi];
    end
`else
    assign w_waddr = r_wcnt;
`endif

    // Only the next sequential address is ever fetched; R_PRE fetches slot 0.
    assign w_rd_addr = (r_rstate == R_SEND) ? r_raddr + AW'(1) : '0;
    assign w_rd_data = r_mem[{r_rbank, w_rd_addr}];

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[{r_wbank, w_waddr}] <= {i_xI, i_xQ};
        end
    end

    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_wcnt_nxt     = r_wcnt;
        w_wbank_nxt    = r_wbank;
        w_overrun_nxt  = r_overrun;
        w_sync_err_nxt = r_sync_err;
        w_full_set     = 2'b00;
        w_we           = 1'b0;
        w_do_start     = 1'b0;

        case (r_wstate)
            W_IDLE: begin
                if (i_start) begin
                    w_do_start = 1'b1;
                end
            end
            W_FILL: begin
                if (i_start) begin
                    w_do_start     = 1'b1;
                    w_sync_err_nxt = 1'b1;
                end else if (i_valid) begin
                    w_we       = 1'b1;
                    w_wcnt_nxt = r_wcnt + AW'(1);
                    if (r_wcnt == c_last_addr) begin
                        w_full_set[r_wbank] = 1'b1;
                        w_wbank_nxt         = ~r_wbank;
                        w_wstate_nxt        = W_IDLE;
                    end
                end
            end
            W_DROP: begin
                if (i_start) begin
                    w_do_start     = 1'b1;
                    w_sync_err_nxt = 1'b1;
                end else if (i_valid) begin
                    w_wcnt_nxt = r_wcnt + AW'(1);
                    if (r_wcnt == c_last_addr) begin
                        w_wstate_nxt = W_IDLE;
                    end
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase

        // A new frame (first or resync) is admitted only into an empty bank.
        if (w_do_start) begin
            w_wcnt_nxt = '0;
            if (r_full[r_wbank]) begin
                w_wstate_nxt  = W_DROP;
                w_overrun_nxt = 1'b1;
            end else begin
                w_wstate_nxt = W_FILL;
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_raddr_nxt  = r_raddr;
        w_rbank_nxt  = r_rbank;
        w_full_clr   = 2'b00;
        w_start_nxt  = 1'b0;
        w_valid_nxt  = r_valid;
        w_last_nxt   = r_last;
        w_xI_nxt     = r_xI;
        w_xQ_nxt     = r_xQ;

        case (r_rstate)
            R_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_rstate_nxt = R_PRE;
                    w_start_nxt  = 1'b1;
                end
            end
            R_PRE: begin
                w_rstate_nxt = R_SEND;
                w_raddr_nxt  = '0;
                w_valid_nxt  = 1'b1;
                w_last_nxt   = 1'b0;
                w_xI_nxt     = w_rd_data[2*WN-1:WN];
                w_xQ_nxt     = w_rd_data[WN-1:0];
            end
            R_SEND: begin
                if (i_ready) begin
                    if (r_raddr == c_last_addr) begin
                        w_full_clr[r_rbank] = 1'b1;
                        w_rbank_nxt         = ~r_rbank;
                        w_valid_nxt         = 1'b0;
                        w_last_nxt          = 1'b0;
                        w_xI_nxt            = '0;
                        w_xQ_nxt            = '0;
                        // Chain straight into the next frame if it is waiting.
                        if (r_full[~r_rbank]) begin
                            w_rstate_nxt = R_PRE;
                            w_start_nxt  = 1'b1;
                        end else begin
                            w_rstate_nxt = R_IDLE;
                        end
                    end else begin
                        w_raddr_nxt = w_rd_addr;
                        w_last_nxt  = (w_rd_addr == c_last_addr);
                        w_xI_nxt    = w_rd_data[2*WN-1:WN];
                        w_xQ_nxt    = w_rd_data[WN-1:0];
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wstate   <= W_IDLE;
            r_rstate   <= R_IDLE;
            r_wcnt     <= '0;
            r_raddr    <= '0;
            r_wbank    <= 1'b0;
            r_rbank    <= 1'b0;
            r_full     <= 2'b00;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
            r_start    <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_xI       <= '0;
            r_xQ       <= '0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_rstate   <= w_rstate_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_raddr    <= w_raddr_nxt;
            r_wbank    <= w_wbank_nxt;
            r_rbank    <= w_rbank_nxt;
            r_full     <= (r_full | w_full_set) & ~w_full_clr;
            r_overrun  <= w_overrun_nxt;
            r_sync_err <= w_sync_err_nxt;
            r_start    <= w_start_nxt;
            r_valid    <= w_valid_nxt;
            r_last     <= w_last_nxt;
            r_xI       <= w_xI_nxt;
            r_xQ       <= w_xQ_nxt;
        end
    end

    assign o_start    = r_start;
    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_xI       = r_xI;
    assign o_xQ       = r_xQ;
    assign o_overrun  = r_overrun;
    assign o_sync_err = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_fft_bitrev_buf.sv
// ============================================================================
// Module   : tb_fft_bitrev_buf
// Purpose  : Self-checking bench for fft_bitrev_buf (NFFT=8, WN=9).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_bitrev_buf;

    localparam int NFFT = 8;
    localparam int WN   = 9;
    localparam int LG   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_start = 1'b0;
    logic                 i_valid = 1'b0;
    logic signed [WN-1:0] i_xI = '0;
    logic signed [WN-1:0] i_xQ = '0;
    logic                 i_ready = 1'b0;
    logic                 o_start, o_valid, o_last, o_overrun, o_sync_err;
    logic signed [WN-1:0] o_xI, o_xQ;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    logic [2*WN-1:0] tx_frame [NFFT];
    logic [2*WN:0]   rx_q [$];
    logic [2*WN:0]   exp_q [$];

    // monitor history
    logic            p_valid = 1'b0, p_ready = 1'b0, p_start = 1'b0;
    logic [2*WN:0]   p_data = '0;

    fft_bitrev_buf #(.NFFT(NFFT), .WN(WN)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_valid    (i_valid),
        .i_xI       (i_xI),
        .i_xQ       (i_xQ),
        .i_ready    (i_ready),
        .o_start    (o_start),
        .o_valid    (o_valid),
        .o_last     (o_last),
        .o_xI       (o_xI),
        .o_xQ       (o_xQ),
        .o_overrun  (o_overrun),
        .o_sync_err (o_sync_err)
    );

    always #5 clk = ~clk;

    // Output slot k carries input sample bitrev(k) (natural order without the macro).
    function automatic int slot_src(input int k);
        int r;
        r = k;
`ifdef FFT_BITREV_EN
        r = 0;
        for (int i = 0; i < LG; i++) r = (r * 2) + ((k >> i) & 1);
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_start = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                n_cmp++;
                if (!o_valid || {o_last, o_xI, o_xQ} !== p_data) begin
                    n_bad++;
                    $display("FAIL hold_stable: got v=%0b %h want v=1 %h", o_valid, {o_last, o_xI, o_xQ}, p_data);
                end
            end
            if (p_start) begin
                n_cmp++;
                if (o_valid !== 1'b1 || p_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL start_to_valid: got valid=%0b prev_valid=%0b want 1/0", o_valid, p_valid);
                end
            end
            if (!o_valid) begin
                n_cmp++;
                if ({o_last, o_xI, o_xQ} !== '0) begin
                    n_bad++;
                    $display("FAIL idle_zero: got %h want 0", {o_last, o_xI, o_xQ});
                end
            end
            if (o_start) start_cnt++;
            if (o_valid && i_ready) rx_q.push_back({o_last, o_xI, o_xQ});
            p_valid = o_valid;
            p_ready = i_ready;
            p_start = o_start;
            p_data  = {o_last, o_xI, o_xQ};
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        i_start = 1'b0; i_valid = 1'b0; i_xI = '0; i_xQ = '0; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
        start_cnt = 0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < NFFT; k++) tx_frame[k] = (2*WN)'($urandom);
    endtask

    task automatic push_exp();
        for (int k = 0; k < NFFT; k++)
            exp_q.push_back({(k == NFFT-1) ? 1'b1 : 1'b0, tx_frame[slot_src(k)]});
    endtask

    // Start pulse (optionally with an ignored junk valid) then NFFT valids.
    task automatic send_frame(input int gap_pct, input bit vstart);
        @(posedge clk); #2;
        i_start = 1'b1; i_valid = vstart; i_xI = 9'sd99; i_xQ = -9'sd99;
        @(posedge clk); #2;
        i_start = 1'b0; i_valid = 1'b0;
        for (int k = 0; k < NFFT; k++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(99) < gap_pct) begin
                    i_valid = 1'b0;
                    @(posedge clk); #2;
                end
            end
            i_valid = 1'b1;
            {i_xI, i_xQ} = tx_frame[k];
            @(posedge clk); #2;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_rx(output bit timed_out);
        int t;
        t = 0;
        while (rx_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        timed_out = (rx_q.size() < exp_q.size());
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_start, o_valid, o_last, o_xI, o_xQ, o_overrun, o_sync_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {o_start, o_valid, o_last, o_xI, o_xQ, o_overrun, o_sync_err});
        end
        apply_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({o_start, o_valid, o_last, o_xI, o_xQ, o_overrun, o_sync_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: got %h want 0", {o_start, o_valid, o_last, o_xI, o_xQ, o_overrun, o_sync_err});
        end
    endtask

    task automatic test_single_frame();
        bit to;
        apply_reset();
        i_ready = 1'b1;
        for (int k = 0; k < NFFT; k++) tx_frame[k] = {9'(k), 9'(-k)};
        push_exp();
        send_frame(0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (o_start !== 1'b0) begin
            n_bad++; $display("FAIL latency_t0: got o_start=%0b want 0", o_start);
        end
        @(negedge clk);
        n_cmp++;
        if (o_start !== 1'b1 || o_valid !== 1'b0) begin
            n_bad++; $display("FAIL latency_t1: got start=%0b valid=%0b want 1/0", o_start, o_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (o_start !== 1'b0 || o_valid !== 1'b1) begin
            n_bad++; $display("FAIL latency_t2: got start=%0b valid=%0b want 0/1", o_start, o_valid);
        end
        wait_rx(to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL single_timeout: got %0d samples want %0d", rx_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if ((k < rx_q.size() ? rx_q[k] : 'x) !== exp_q[k]) begin
                n_bad++; $display("FAIL single_sample%0d: got %h want %h", k, (k < rx_q.size() ? rx_q[k] : 'x), exp_q[k]);
            end
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size() || start_cnt != 1) begin
            n_bad++; $display("FAIL single_count: got %0d samples %0d starts want %0d/1", rx_q.size(), start_cnt, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit to;
        apply_reset();
        fill_random();
        push_exp();
        send_frame(0, 1'b0);
        for (int c = 0; c < 90; c++) begin
            i_ready = (c % 3 == 0);
            @(posedge clk); #2;
        end
        i_ready = 1'b1;
        wait_rx(to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL bp_timeout: got %0d samples want %0d", rx_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if ((k < rx_q.size() ? rx_q[k] : 'x) !== exp_q[k]) begin
                n_bad++; $display("FAIL bp_sample%0d: got %h want %h", k, (k < rx_q.size() ? rx_q[k] : 'x), exp_q[k]);
            end
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL bp_count: got %0d want %0d", rx_q.size(), exp_q.size());
        end
    endtask

    task automatic test_overrun();
        bit to;
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            fill_random();
            if (f < 2) push_exp();
            send_frame(0, 1'b0);
            repeat (3 * NFFT - NFFT - 1) @(posedge clk);
            #2;
            n_cmp++;
            if (o_overrun !== (f == 2)) begin
                n_bad++; $display("FAIL overrun_frame%0d: got %0b want %0b", f, o_overrun, (f == 2));
            end
        end
        n_cmp++;
        if (rx_q.size() != 0) begin
            n_bad++; $display("FAIL overrun_stall: got %0d samples want 0", rx_q.size());
        end
        i_ready = 1'b1;
        wait_rx(to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL overrun_timeout: got %0d samples want %0d", rx_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if ((k < rx_q.size() ? rx_q[k] : 'x) !== exp_q[k]) begin
                n_bad++; $display("FAIL overrun_sample%0d: got %h want %h", k, (k < rx_q.size() ? rx_q[k] : 'x), exp_q[k]);
            end
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size() || o_overrun !== 1'b1 || o_sync_err !== 1'b0) begin
            n_bad++; $display("FAIL overrun_final: got %0d samples ovr=%0b sync=%0b want %0d/1/0",
                              rx_q.size(), o_overrun, o_sync_err, exp_q.size());
        end
    endtask

    task automatic test_resync();
        bit to;
        apply_reset();
        i_ready = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; {i_xI, i_xQ} = 18'($urandom);
            @(posedge clk); #2;
        end
        i_valid = 1'b0;
        for (int k = 0; k < NFFT; k++) tx_frame[k] = {9'(10 + k), 9'($urandom)};
        push_exp();
        send_frame(0, 1'b1);
        wait_rx(to);
        n_cmp++;
        if (o_sync_err !== 1'b1 || o_overrun !== 1'b0) begin
            n_bad++; $display("FAIL resync_flags: got sync=%0b ovr=%0b want 1/0", o_sync_err, o_overrun);
        end
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL resync_timeout: got %0d samples want %0d", rx_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if ((k < rx_q.size() ? rx_q[k] : 'x) !== exp_q[k]) begin
                n_bad++; $display("FAIL resync_sample%0d: got %h want %h", k, (k < rx_q.size() ? rx_q[k] : 'x), exp_q[k]);
            end
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL resync_count: got %0d want %0d", rx_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid_send();
        bit to;
        int t;
        apply_reset();
        fill_random();
        send_frame(0, 1'b0);
        t = 0;
        while (!o_valid && t < 50) begin @(posedge clk); #2; t++; end
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 i_ready = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_start, o_valid, o_last, o_xI, o_xQ, o_overrun, o_sync_err} !== '0) begin
            n_bad++; $display("FAIL midsend_reset: got %h want 0", {o_start, o_valid, o_last, o_xI, o_xQ, o_overrun, o_sync_err});
        end
        apply_reset();
        i_ready = 1'b1;
        fill_random();
        push_exp();
        send_frame(30, 1'b0);
        wait_rx(to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL midsend_timeout: got %0d samples want %0d", rx_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if ((k < rx_q.size() ? rx_q[k] : 'x) !== exp_q[k]) begin
                n_bad++; $display("FAIL midsend_sample%0d: got %h want %h", k, (k < rx_q.size() ? rx_q[k] : 'x), exp_q[k]);
            end
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size() || o_overrun !== 1'b0 || o_sync_err !== 1'b0) begin
            n_bad++; $display("FAIL midsend_final: got %0d samples ovr=%0b sync=%0b want %0d/0/0",
                              rx_q.size(), o_overrun, o_sync_err, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        apply_reset();
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    fill_random();
                    push_exp();
                    send_frame(0, (f % 2) == 1);
                    repeat (3 * NFFT - NFFT - 1) @(posedge clk);
                end
            end
            begin
                for (int c = 0; c < 4 * 3 * NFFT + 40; c++) begin
                    i_ready = (c % 2 == 0) ? 1'b1 : 1'($urandom_range(1));
                    @(posedge clk); #2;
                end
                i_ready = 1'b1;
            end
        join
        wait_rx(to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL b2b_timeout: got %0d samples want %0d", rx_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if ((k < rx_q.size() ? rx_q[k] : 'x) !== exp_q[k]) begin
                n_bad++; $display("FAIL b2b_sample%0d: got %h want %h", k, (k < rx_q.size() ? rx_q[k] : 'x), exp_q[k]);
            end
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size() || start_cnt != 4 || o_overrun !== 1'b0) begin
            n_bad++; $display("FAIL b2b_final: got %0d samples %0d starts ovr=%0b want %0d/4/0",
                              rx_q.size(), start_cnt, o_overrun, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overrun();
        test_resync();
        test_reset_mid_send();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
